// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: alternates one READ and one WRITE cycle per word,
// walking source and destination upward from the latched start addresses.
module mem_copy_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Len,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  WordCount,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] DataAddress,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_t            state_r;
  state_t            stateNext_s;
  logic [ADDR_W-1:0] srcAddr_r;
  logic [ADDR_W-1:0] dstAddr_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  index_r;
  logic [LEN_W-1:0]  indexNext_s;
  logic [LEN_W-1:0]  wordCount_r;
  logic [DATA_W-1:0] wordBuf_r;
  logic              memRead_s;
  logic              memWrite_s;
  logic [ADDR_W-1:0] dataAddress_s;
  logic              busy_s;
  logic              done_s;

  assign indexNext_s = index_r + LEN_ONE;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state and state-decoded outputs; Abort only suppresses the write strobe combinationally
  always_comb begin
    stateNext_s   = state_r;
    memRead_s     = 1'b0;
    memWrite_s    = 1'b0;
    dataAddress_s = ADDR_ZERO;
    busy_s        = 1'b1;
    done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (Start) begin
          if (Len != LEN_ZERO) begin
            stateNext_s = READ;
          end else begin
            stateNext_s = DONE;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      READ: begin
        memRead_s     = 1'b1;
        dataAddress_s = srcAddr_r + ADDR_W'(index_r);
        if (Abort) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = WRITE;
        end
      end
      WRITE: begin
        memWrite_s    = ~Abort;
        dataAddress_s = dstAddr_r + ADDR_W'(index_r);
        if (Abort) begin
          stateNext_s = IDLE;
        end else if (indexNext_s == len_r) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = READ;
        end
      end
      DONE: begin
        done_s      = 1'b1;
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // Transfer parameters, progress counters and the single-word buffer
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      srcAddr_r   <= ADDR_ZERO;
      dstAddr_r   <= ADDR_ZERO;
      len_r       <= LEN_ZERO;
      index_r     <= LEN_ZERO;
      wordCount_r <= LEN_ZERO;
      wordBuf_r   <= DATA_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            wordCount_r <= LEN_ZERO;
            if (Len != LEN_ZERO) begin
              srcAddr_r <= SrcAddr;
              dstAddr_r <= DstAddr;
              len_r     <= Len;
              index_r   <= LEN_ZERO;
            end else begin
              index_r <= index_r;
            end
          end else begin
            wordCount_r <= wordCount_r;
          end
        end
        READ: begin
          if (!Abort) begin
            wordBuf_r <= DataOut;
          end else begin
            wordBuf_r <= wordBuf_r;
          end
        end
        WRITE: begin
          // an aborted write leaves the count at the words actually committed
          if (!Abort) begin
            index_r     <= indexNext_s;
            wordCount_r <= wordCount_r + LEN_ONE;
          end else begin
            index_r <= index_r;
          end
        end
        default: begin
          index_r <= index_r;
        end
      endcase
    end
  end

  assign Busy        = busy_s;
  assign Done        = done_s;
  assign MemRead     = memRead_s;
  assign MemWrite    = memWrite_s;
  assign DataAddress = dataAddress_s;
  assign DataIn      = wordBuf_r;
  assign WordCount   = wordCount_r;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: behavioural memory, scoreboard of expected reads/writes,
// table-driven copies plus hand-written abort, restart, overlap and reset sequences.
module tb_mem_copy_dma;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] SrcAddr = 16'd0;
  logic [15:0] DstAddr = 16'd0;
  logic [7:0]  Len = 8'd0;
  logic        Busy, Done, MemRead, MemWrite;
  logic [7:0]  WordCount;
  logic [15:0] DataAddress, DataIn, DataOut;

  mem_copy_dma #(.ADDR_W(16), .DATA_W(16), .LEN_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Abort(Abort),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
    .Busy(Busy), .Done(Done), .WordCount(WordCount),
    .MemRead(MemRead), .MemWrite(MemWrite), .DataAddress(DataAddress),
    .DataIn(DataIn), .DataOut(DataOut)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct packed {
    logic [15:0]      src;
    logic [15:0]      dst;
    logic [7:0]       len;
    logic [3:0][15:0] d;
    logic             abt;
    int               expDone;
    logic [7:0]       expWc;
  } vec_t;

  logic [15:0] mem [0:65535];
  wr_t         expQ[$];
  logic [15:0] rdExpQ[$];
  int          checks = 0;
  int          errors = 0;
  int          rdCnt = 0;
  int          wrCnt = 0;
  logic        preWe = 1'b0;
  logic [15:0] preAddr = 16'd0;
  logic [15:0] preData = 16'd0;

  assign DataOut = mem[DataAddress];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Memory model and scoreboard: the only process that writes mem
  always @(posedge CLK) begin
    wr_t         e;
    logic [15:0] ea;
    if (preWe) mem[preAddr] = preData;
    if (MemWrite) begin
      mem[DataAddress] = DataIn;
      wrCnt++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", DataAddress, DataIn);
      end else begin
        e = expQ.pop_front();
        check("wr_addr", {16'd0, DataAddress}, {16'd0, e.a});
        check("wr_data", {16'd0, DataIn}, {16'd0, e.d});
      end
    end
    if (MemRead) begin
      rdCnt++;
      if (rdExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read addr=%0h", DataAddress);
      end else begin
        ea = rdExpQ.pop_front();
        check("rd_addr", {16'd0, DataAddress}, {16'd0, ea});
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge CLK);
    preWe = 1'b1; preAddr = a; preData = d;
    @(posedge CLK);
    #1 preWe = 1'b0;
  endtask

  function automatic logic [15:0] wordOf(input vec_t v, input int i);
    logic [15:0] w;
    w = v.d[i % 4];
    if (v.len > 8'd4) w = w + 16'(i);
    return w;
  endfunction

  // Start one copy and time it; glitchC>0 re-pulses Start with other parameters in that cycle
  task automatic runCopy(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                         input int expDone, input logic [7:0] expWc, input string nm,
                         input bit relRst, input int glitchC);
    int doneCyc;
    int r0;
    int w0;
    r0 = rdCnt;
    w0 = wrCnt;
    @(negedge CLK);
    if (relRst) RST_N = 1'b1;
    SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1;
    @(posedge CLK);
    doneCyc = -1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (c == glitchC) begin
        Start = 1'b1; SrcAddr = s + 16'd200; DstAddr = d + 16'd50; Len = 8'd9;
      end
      if (Done) begin
        doneCyc = c;
        break;
      end
    end
    Start = 1'b0;
    check({nm, "_done_cycle"}, doneCyc, expDone);
    check({nm, "_wordcount"}, {24'd0, WordCount}, {24'd0, expWc});
    check({nm, "_busy_in_done"}, {31'd0, Busy}, 32'd1);
    @(negedge CLK);
    check({nm, "_done_one_cycle"}, {31'd0, Done}, 32'd0);
    check({nm, "_idle_after"}, {31'd0, Busy}, 32'd0);
    check({nm, "_reads"}, rdCnt - r0, {24'd0, l});
    check({nm, "_writes"}, wrCnt - w0, {24'd0, l});
    check({nm, "_sb_empty"}, expQ.size() + rdExpQ.size(), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string nm);
    check({nm, "_busy"}, {31'd0, Busy}, 32'd0);
    check({nm, "_done"}, {31'd0, Done}, 32'd0);
    check({nm, "_memread"}, {31'd0, MemRead}, 32'd0);
    check({nm, "_memwrite"}, {31'd0, MemWrite}, 32'd0);
    check({nm, "_addr"}, {16'd0, DataAddress}, 32'd0);
    check({nm, "_datain"}, {16'd0, DataIn}, 32'd0);
    check({nm, "_wordcount"}, {24'd0, WordCount}, 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int          doneSeen;
    logic [15:0] w;

    vecs[0] = '{src: 16'd96, dst: 16'd200, len: 8'd4, d: {16'd0, 16'd12455, 16'd0, 16'd5},
                abt: 1'b0, expDone: 9, expWc: 8'd4};
    vecs[1] = '{src: 16'd10, dst: 16'd20, len: 8'd0, d: {16'd0, 16'd0, 16'd0, 16'd0},
                abt: 1'b1, expDone: 1, expWc: 8'd0};
    vecs[2] = '{src: 16'hFFFE, dst: 16'h0010, len: 8'd3, d: {16'd0, 16'h00C3, 16'h00B2, 16'h00A1},
                abt: 1'b0, expDone: 7, expWc: 8'd3};
    vecs[3] = '{src: 16'h1000, dst: 16'h2000, len: 8'd1, d: {16'd0, 16'd0, 16'd0, 16'hBEEF},
                abt: 1'b0, expDone: 3, expWc: 8'd1};
    vecs[4] = '{src: 16'd300, dst: 16'd500, len: 8'd7, d: {16'h4444, 16'h3333, 16'h2222, 16'h1111},
                abt: 1'b0, expDone: 15, expWc: 8'd7};

    #1 checkIdleOutputs("reset");

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        poke(vecs[v].src + 16'(i), wordOf(vecs[v], i));
        rdExpQ.push_back(vecs[v].src + 16'(i));
        expQ.push_back('{a: vecs[v].dst + 16'(i), d: wordOf(vecs[v], i)});
      end
      Abort = vecs[v].abt;
      runCopy(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].expDone, vecs[v].expWc,
              $sformatf("vec%0d", v), v == 0, 0);
      Abort = 1'b0;
      for (int i = 0; i < int'(vecs[v].len); i++)
        check($sformatf("vec%0d_mem%0d", v, i), {16'd0, mem[vecs[v].dst + 16'(i)]},
              {16'd0, wordOf(vecs[v], i)});
    end

    // Abort during the third WRITE of a 5-word copy
    for (int i = 0; i < 5; i++) poke(16'd400 + 16'(i), 16'h0A00 + 16'(i));
    poke(16'd602, 16'hDEAD);
    for (int i = 0; i < 3; i++) rdExpQ.push_back(16'd400 + 16'(i));
    for (int i = 0; i < 2; i++) expQ.push_back('{a: 16'd600 + 16'(i), d: 16'h0A00 + 16'(i)});
    @(negedge CLK);
    SrcAddr = 16'd400; DstAddr = 16'd600; Len = 8'd5; Start = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    Abort = 1'b1;
    #1;
    check("abort_memwrite_gated", {31'd0, MemWrite}, 32'd0);
    check("abort_in_third_write", {16'd0, DataAddress}, 32'd602);
    @(negedge CLK);
    Abort = 1'b0;
    check("abort_idle", {31'd0, Busy}, 32'd0);
    check("abort_wordcount", {24'd0, WordCount}, 32'd2);
    doneSeen = 0;
    for (int c = 0; c < 4; c++) begin
      if (Done) doneSeen++;
      @(negedge CLK);
    end
    check("abort_no_done", doneSeen, 32'd0);
    check("abort_sb_empty", expQ.size() + rdExpQ.size(), 32'd0);
    check("abort_mem602_kept", {16'd0, mem[16'd602]}, 32'h0000DEAD);

    // Start re-pulsed mid-transfer with different parameters is ignored
    for (int i = 0; i < 3; i++) begin
      poke(16'd700 + 16'(i), 16'h7000 + 16'(i));
      poke(16'd900 + 16'(i), 16'h9000 + 16'(i));
      rdExpQ.push_back(16'd700 + 16'(i));
      expQ.push_back('{a: 16'd800 + 16'(i), d: 16'h7000 + 16'(i)});
    end
    runCopy(16'd700, 16'd800, 8'd3, 7, 8'd3, "restart", 1'b0, 3);

    // Overlapping forward copy replicates the first word
    poke(16'd50, 16'd7); poke(16'd51, 16'd8); poke(16'd52, 16'd9);
    for (int i = 0; i < 3; i++) begin
      rdExpQ.push_back(16'd50 + 16'(i));
      expQ.push_back('{a: 16'd51 + 16'(i), d: 16'd7});
    end
    runCopy(16'd50, 16'd51, 8'd3, 7, 8'd3, "overlap", 1'b0, 0);

    // Reset mid-transfer, dropped once the second word has committed
    for (int i = 0; i < 4; i++) begin
      poke(16'd1000 + 16'(i), 16'h5A00 + 16'(i));
      poke(16'd1100 + 16'(i), 16'hDEAD);
    end
    for (int i = 0; i < 2; i++) begin
      rdExpQ.push_back(16'd1000 + 16'(i));
      expQ.push_back('{a: 16'd1100 + 16'(i), d: 16'h5A00 + 16'(i)});
    end
    @(negedge CLK);
    SrcAddr = 16'd1000; DstAddr = 16'd1100; Len = 8'd4; Start = 1'b1;
    @(posedge CLK);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    RST_N = 1'b0;
    #1 checkIdleOutputs("midreset");
    doneSeen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (Done) doneSeen++;
    end
    check("midreset_no_done", doneSeen, 32'd0);
    check("midreset_sb_empty", expQ.size() + rdExpQ.size(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      w = (i < 2) ? 16'h5A00 + 16'(i) : 16'hDEAD;
      check($sformatf("midreset_mem%0d", i), {16'd0, mem[16'd1100 + 16'(i)]}, {16'd0, w});
    end

    // First Start after reset release is honoured
    poke(16'd1200, 16'h1234);
    rdExpQ.push_back(16'd1200);
    expQ.push_back('{a: 16'd1300, d: 16'h1234});
    runCopy(16'd1200, 16'd1300, 8'd1, 3, 8'd1, "postreset", 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
